seq_checker: RTL
================

// Module: seq_checker
// PURPOSE
//  Downstream monitor for the 4-bit 13-state sequence generator.
//  - Samples the generator output on every enabled step and locks onto the cycle.
//  - Flags any sample that breaks the cycle and counts such errors.
//  - Counts completed periods for system-level health reporting.
// PARAMETERS
//  LOCK_N  3  consecutive correct samples needed to go from VERIFY to LOCKED (>=1)
//  MISS_N  2  consecutive mismatches in LOCKED that drop lock (>=1)
//  CNT_W   8  width of err_cnt and period_cnt
// PORTS
//  clk         in   1      rising-edge clock; one clock domain
//  rst         in   1      asynchronous, active-low reset
//  din         in   4      generator output y
//  din_vld     in   1      generator enable; din is a new sample only when 1
//  resync      in   1      generator load strobe; sequence discontinuity
//  locked      out  1      1 while in LOCKED
//  err         out  1      one-cycle pulse per mismatch detected in LOCKED
//  err_cnt     out  CNT_W  saturating count of err pulses
//  period_cnt  out  CNT_W  count of matched 4'b1000 samples in LOCKED; wraps mod 2^CNT_W
//  expected    out  4      value predicted for the next valid sample
// BEHAVIOUR
//  Cycle order: 1000 7 B 4 2 5 C 6 3 F 1 E D, then back to 1000.
//   next(x) is this successor function.
//  Illegal codes: 0000, 1001, 1010.
//  rst low, asynchronous:
//   - state=HUNT, expected=1000, run=0, miss=0
//   - locked=0, err=0, err_cnt=0, period_cnt=0
//  Outputs are registered. A sample taken at edge k is reflected after edge k.
//   Latency is 1 cycle.
//  Cycles with din_vld=0 change nothing except err, which returns to 0.
//  resync=1 has priority over din_vld:
//   - next state=HUNT, run=0, miss=0, locked=0
//   - din is ignored that cycle
//   - err_cnt and period_cnt are held
//  HUNT, on a valid sample:
//   - legal din: expected=next(din), run=1, go VERIFY (or LOCKED if LOCK_N==1)
//   - illegal din: stay in HUNT
//  VERIFY, on a valid sample:
//   - din==expected: run++, expected=next(din); go LOCKED when run reaches LOCK_N
//   - mismatch, legal din: restart with expected=next(din), run=1
//   - mismatch, illegal din: go HUNT
//   - VERIFY never asserts err
//  LOCKED, on a valid sample:
//   - match: miss=0, expected=next(din); if din==1000 then period_cnt++
//   - mismatch: err=1 for one cycle, err_cnt++ (holds at all-ones), miss++
//   - after a mismatch, expected=next(expected) (flywheel)
//   - when miss reaches MISS_N: go HUNT, locked=0, miss=0
//  err is never asserted outside LOCKED; a dropped sample counts as a mismatch.
// STRUCTURE
//  Package seq_pkg:
//   - the 13 code constants and the illegal-code list
//   - state enum {HUNT, VERIFY, LOCKED}
//   - functions next_code() and is_legal(); generator and checker share these
//  One sub-module, seq_next: combinational din -> {next, legal} lookup,
//   one instance on din and one on expected.
//  Top level: FSM, run/miss counters, output registers.
// TESTING
//  1. Reset, then 13 valid samples starting at 1000, LOCK_N=3:
//     locked=1 after the 3rd sample; err never asserted;
//     period_cnt=1 once the next 1000 arrives.
//  2. Locked, then 0101 is replaced by 0000:
//     one err pulse; err_cnt=1; locked stays 1; the following 1100 matches.
//  3. Locked, then two consecutive wrong samples (MISS_N=2):
//     err_cnt increases by 2; locked=0 the cycle after the 2nd miss; state HUNT.
//  4. resync together with din_vld and din=0100 while locked:
//     locked=0 and err=0; din ignored; the next valid legal sample enters VERIFY.
//  5. Hold din_vld=0 for 10 cycles mid-sequence, then resume correctly:
//     no err, state and expected unchanged.
//  6. CNT_W=2, force 5 errors:
//     err_cnt saturates at 3; drop rst mid-sequence and all outputs clear immediately.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared code table for the 4-bit 13-state sequence generator and its checker.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Cycle order: 8 7 B 4 2 5 C 6 3 F 1 E D, then back to 8.
  localparam logic [3:0] CODE_HEAD = 4'b1000;
  localparam logic [3:0] CODE_01   = 4'b0111;
  localparam logic [3:0] CODE_02   = 4'b1011;
  localparam logic [3:0] CODE_03   = 4'b0100;
  localparam logic [3:0] CODE_04   = 4'b0010;
  localparam logic [3:0] CODE_05   = 4'b0101;
  localparam logic [3:0] CODE_06   = 4'b1100;
  localparam logic [3:0] CODE_07   = 4'b0110;
  localparam logic [3:0] CODE_08   = 4'b0011;
  localparam logic [3:0] CODE_09   = 4'b1111;
  localparam logic [3:0] CODE_10   = 4'b0001;
  localparam logic [3:0] CODE_11   = 4'b1110;
  localparam logic [3:0] CODE_12   = 4'b1101;

  localparam int         N_ILLEGAL = 3;
  localparam logic [3:0] ILLEGAL [N_ILLEGAL] = '{4'b0000, 4'b1001, 4'b1010};

  function automatic logic is_legal(input logic [3:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N_ILLEGAL; i++) begin
      if (code == ILLEGAL[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Illegal codes map to the head of the cycle; callers qualify with is_legal().
  function automatic logic [3:0] next_code(input logic [3:0] code);
    logic [3:0] nxt;
    case (code)
      CODE_HEAD: nxt = CODE_01;
      CODE_01:   nxt = CODE_02;
      CODE_02:   nxt = CODE_03;
      CODE_03:   nxt = CODE_04;
      CODE_04:   nxt = CODE_05;
      CODE_05:   nxt = CODE_06;
      CODE_06:   nxt = CODE_07;
      CODE_07:   nxt = CODE_08;
      CODE_08:   nxt = CODE_09;
      CODE_09:   nxt = CODE_10;
      CODE_10:   nxt = CODE_11;
      CODE_11:   nxt = CODE_12;
      CODE_12:   nxt = CODE_HEAD;
      default:   nxt = CODE_HEAD;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Sample/status bundle between a sequence source and the checker.
// Latency: none (wiring only).
// Backpressure: none; the source pushes a sample whenever din_vld is high.
// Ports: din/din_vld/resync from source; locked/err/err_cnt/period_cnt/expected from checker.
interface seq_checker_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       din;
  logic             din_vld;
  logic             resync;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [3:0]       expected;

  modport master (
    output din, din_vld, resync,
    input  locked, err, err_cnt, period_cnt, expected
  );

  modport slave (
    input  din, din_vld, resync,
    output locked, err, err_cnt, period_cnt, expected
  );
endinterface

// File: rtl/seq_next.sv
// Combinational successor lookup: code -> {next code, legal flag}.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
// Ports: code_i (4b) in; nxt_o (4b) successor, legal_o high for a cycle member.
module seq_next
  import seq_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] nxt_o,
  output logic       legal_o
);
  assign nxt_o   = next_code(code_i);
  assign legal_o = is_legal(code_i);
endmodule

// File: rtl/seq_checker.sv
// Monitors the 13-state generator output: locks on, flags breaks, counts errors and periods.
// Latency: 1 cycle; a sample taken at edge k is reflected in all outputs after edge k.
// Backpressure: none; every din_vld sample is consumed, resync overrides it.
// Ports: clk, rst (async active-low), bus (slave: din/din_vld/resync in; status out).
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int MISS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_checker_if.slave bus
);
  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(MISS_N + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_N);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_N);

  state_t             state_q;
  logic [3:0]         expected_q;
  logic [RUN_W-1:0]   run_q;
  logic [MISS_W-1:0]  miss_q;
  logic               locked_q;
  logic               err_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   period_cnt_q;

  logic [3:0]         nxt_din;
  logic               legal_din;
  logic [3:0]         nxt_exp;
  logic               legal_exp;
  logic               match;
  logic [RUN_W-1:0]   run_d;
  logic [MISS_W-1:0]  miss_d;
  logic [CNT_W-1:0]   err_cnt_d;

  seq_next u_next_din (.code_i(bus.din),    .nxt_o(nxt_din), .legal_o(legal_din));
  seq_next u_next_exp (.code_i(expected_q), .nxt_o(nxt_exp), .legal_o(legal_exp));

  // expected_q only ever holds successor codes, so legal_exp is normally 1;
  // the guard stops a corrupted prediction register from ever producing a match.
  assign match     = (bus.din == expected_q) && legal_exp;
  assign run_d     = run_q + RUN_W'(1);
  assign miss_d    = miss_q + MISS_W'(1);
  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      expected_q   <= CODE_HEAD;
      run_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      period_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;  // err is a single-cycle pulse
      if (bus.resync) begin
        state_q  <= HUNT;
        run_q    <= '0;
        miss_q   <= '0;
        locked_q <= 1'b0;
      end else if (bus.din_vld) begin
        case (state_q)
          HUNT: begin
            if (legal_din) begin
              expected_q <= nxt_din;
              run_q      <= RUN_W'(1);
              miss_q     <= '0;
              if (LOCK_N == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q  <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (match) begin
              run_q      <= run_d;
              expected_q <= nxt_din;
              if (run_d == RUN_LOCK) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else if (legal_din) begin
              // Restart the run on the new legal phase.
              expected_q <= nxt_din;
              run_q      <= RUN_W'(1);
            end else begin
              state_q <= HUNT;
              run_q   <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_q     <= '0;
              expected_q <= nxt_din;
              if (bus.din == CODE_HEAD) period_cnt_q <= period_cnt_q + CNT_W'(1);
            end else begin
              err_q      <= 1'b1;
              err_cnt_q  <= err_cnt_d;
              // Flywheel: keep predicting as if the sample had been correct.
              expected_q <= nxt_exp;
              if (miss_d == MISS_LIM) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                miss_q   <= '0;
                run_q    <= '0;
              end else begin
                miss_q <= miss_d;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.expected   = expected_q;

endmodule
